unidade_mult_div: RTL and testbench
===================================

UNIDADE_MULT_DIV -- requirements
Module: unidade_mult_div

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Inicio, input, 1 bit: start pulse, sampled only in OCIOSO.
REQ-004 SHALL have port Operacao, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port OperandoA, input, 32 bits: rs value (multiplicand or dividend); also the mthi/mtlo source.
REQ-006 SHALL have port OperandoB, input, 32 bits: rt value (multiplier or divisor).
REQ-007 SHALL have port EscreveHi, input, 1 bit: mthi request.
REQ-008 SHALL have port EscreveLo, input, 1 bit: mtlo request.
REQ-009 SHALL have port Ocupado, output, 1 bit: operation in progress; the control unit stalls the PC while it is high.
REQ-010 SHALL have port Pronto, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port DivPorZero, output, 1 bit: valid while Pronto is high.
REQ-012 SHALL have port Hi, output, 32 bits: HI register, read combinationally for mfhi.
REQ-013 SHALL have port Lo, output, 32 bits: LO register, read combinationally for mflo.

Function
REQ-014 SHALL implement FSM states OCIOSO, CALCULA, AJUSTE and FIM.
- OCIOSO -> CALCULA on Inicio.
- CALCULA -> AJUSTE after exactly 32 iterations.
- AJUSTE -> FIM.
- FIM -> OCIOSO.
REQ-015 SHALL latch Operacao, OperandoA and OperandoB when Inicio is sampled (cycle N); later input changes SHALL NOT affect the result.
REQ-016 SHALL drive Ocupado high in cycles N+1 through N+33 (CALCULA and AJUSTE).
REQ-017 SHALL assert Pronto in cycle N+34 (state FIM) only, with Hi and Lo already holding the new result.
REQ-018 Multiply SHALL use a radix-2 shift-add algorithm on operand magnitudes.
- Sign correction applied in AJUSTE for MULT.
- Result: {Hi,Lo} = 64-bit product.
REQ-019 Divide SHALL use restoring division on operand magnitudes.
- Lo = quotient truncated toward zero; Hi = remainder carrying the sign of the dividend.
- Signed fix applied in AJUSTE.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield Lo = 0x80000000, Hi = 0x00000000, with no flag.
REQ-021 A divisor of zero SHALL still take the full latency, leave Hi and Lo unchanged, and assert DivPorZero together with Pronto.
REQ-022 Hi and Lo SHALL hold their previous values throughout CALCULA and AJUSTE; working values live in internal registers.
REQ-023 Inicio while not in OCIOSO SHALL be ignored (no queuing).
REQ-024 EscreveHi / EscreveLo in OCIOSO with Inicio low SHALL load OperandoA into Hi / Lo at the next edge.
- Both may be asserted in the same cycle.
- Both are ignored in any other state.
REQ-025 Inicio together with EscreveHi or EscreveLo in OCIOSO SHALL start the operation and discard the write.
REQ-026 Inicio asserted in FIM SHALL be ignored; a back-to-back operation starts no earlier than the cycle after FIM.

Reset
REQ-027 Reset SHALL force state OCIOSO, Hi = 0, Lo = 0, Ocupado = 0, Pronto = 0, DivPorZero = 0 and clear the iteration counter at the next rising edge.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no result written and no Pronto pulse.
REQ-029 Reset SHALL take priority over Inicio, EscreveHi and EscreveLo.

Structure
REQ-030 The Operacao codes, FSM state encodings, data width (32) and iteration count (32) SHALL be defined in the shared processor package.
REQ-031 SHALL be a single module with one shared 64-bit shift datapath and a 6-bit iteration counter; no sub-module.

Verification
REQ-032 MULTU with A = 0xFFFFFFFF, B = 0xFFFFFFFF -> Pronto at N+34; Hi = 0xFFFFFFFE, Lo = 0x00000001; Ocupado high for exactly 33 cycles.
REQ-033 MULT with A = -3 (0xFFFFFFFD), B = 7 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB.
REQ-034 DIV with A = -7, B = 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF; DIVU with A = 7, B = 2 -> Lo = 3, Hi = 1.
REQ-035 DIVU with A = 5, B = 0, where Hi = 0x11, Lo = 0x22 beforehand -> DivPorZero = 1 with Pronto; Hi/Lo remain 0x11/0x22.
REQ-036 Start MULTU, then pulse Inicio and EscreveLo at N+5 and change the operands -> result unaffected and Lo not written; then EscreveHi in OCIOSO with A = 0xCAFEBABE -> Hi = 0xCAFEBABE next cycle.
REQ-037 Reset at N+10 of a DIV -> next cycle: OCIOSO, Hi = Lo = 0, Ocupado = 0; no Pronto in the following 40 cycles.

Source files
------------

// File: rtl/unidade_mult_div_pkg.sv
// rtl/unidade_mult_div_pkg.sv - shared opcodes, state encoding and sizes for the mult/div unit
package unidade_mult_div_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    CALCULA = 2'b01,
    AJUSTE  = 2'b10,
    FIM     = 2'b11
  } estado_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is exactly the unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic signed_op);
    return (signed_op && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/unidade_mult_div.sv
// rtl/unidade_mult_div.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// One 64-bit shift register serves both shift-add multiply and restoring divide.
module unidade_mult_div
  import unidade_mult_div_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Inicio,
  input  logic [1:0]        Operacao,
  input  logic [DATA_W-1:0] OperandoA,
  input  logic [DATA_W-1:0] OperandoB,
  input  logic              EscreveHi,
  input  logic              EscreveLo,
  output logic              Ocupado,
  output logic              Pronto,
  output logic              DivPorZero,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  estado_e                 estado_q, estado_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0]       b_q, b_d;
  logic                    is_div_q, is_div_d;
  logic                    sa_q, sa_d;
  logic                    sb_q, sb_d;
  logic                    zero_q, zero_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;

  logic                    start_signed;
  logic                    start_div;
  logic [DATA_W:0]         mul_sum;
  logic [DATA_W:0]         div_shift;
  logic                    div_ge;
  logic [DATA_W-1:0]       div_rem;
  logic [2*DATA_W-1:0]     prod_fix;
  logic [DATA_W-1:0]       quo_fix;
  logic [DATA_W-1:0]       rem_fix;

  // State register and all datapath flops
  always_ff @(posedge Clock) begin
    if (Reset) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (Inicio) estado_d = CALCULA;
      CALCULA: if (cnt_q == CNT_W'(ITER_COUNT - 1)) estado_d = AJUSTE;
      AJUSTE:  estado_d = FIM;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    Ocupado    = 1'b0;
    Pronto     = 1'b0;
    DivPorZero = 1'b0;
    case (estado_q)
      CALCULA, AJUSTE: Ocupado = 1'b1;
      FIM: begin
        Pronto     = 1'b1;
        DivPorZero = zero_q;
      end
      default: ;
    endcase
  end

  assign Hi = hi_q;
  assign Lo = lo_q;

  assign start_signed = (Operacao == OP_MULT) || (Operacao == OP_DIV);
  assign start_div    = (Operacao == OP_DIV)  || (Operacao == OP_DIVU);

  // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
  assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, b_q})
                            : {1'b0, acc_q[2*DATA_W-1:DATA_W]};

  // Divide step: shift {rem,quo} left, keep the trial subtraction only if it does not go negative.
  assign div_shift = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_rem   = div_shift[DATA_W-1:0] - b_q;

  assign prod_fix = (sa_q ^ sb_q) ? (~acc_q + (2*DATA_W)'(1)) : acc_q;
  assign quo_fix  = (sa_q ^ sb_q) ? (~acc_q[DATA_W-1:0] + DATA_W'(1)) : acc_q[DATA_W-1:0];
  assign rem_fix  = sa_q ? (~acc_q[2*DATA_W-1:DATA_W] + DATA_W'(1)) : acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (estado_q)
      OCIOSO: begin
        if (Inicio) begin
          cnt_d    = '0;
          acc_d    = {{DATA_W{1'b0}}, magnitude(OperandoA, start_signed)};
          b_d      = magnitude(OperandoB, start_signed);
          is_div_d = start_div;
          sa_d     = start_signed & OperandoA[DATA_W-1];
          sb_d     = start_signed & OperandoB[DATA_W-1];
          zero_d   = start_div && (OperandoB == '0);
        end else begin
          if (EscreveHi) hi_d = OperandoA;
          if (EscreveLo) lo_d = OperandoA;
        end
      end
      CALCULA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_d = div_ge ? {div_rem, acc_q[DATA_W-2:0], 1'b1}
                         : {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end
      end
      AJUSTE: begin
        if (is_div_q) begin
          if (!zero_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unidade_mult_div.sv
// tb/tb_unidade_mult_div.sv - self-checking bench for unidade_mult_div against an arithmetic reference
module tb_unidade_mult_div;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Inicio;
  logic [1:0]  Operacao;
  logic [31:0] OperandoA;
  logic [31:0] OperandoB;
  logic        EscreveHi;
  logic        EscreveLo;
  logic        Ocupado;
  logic        Pronto;
  logic        DivPorZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] hi_m, lo_m;

  unidade_mult_div dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Inicio    (Inicio),
    .Operacao  (Operacao),
    .OperandoA (OperandoA),
    .OperandoB (OperandoB),
    .EscreveHi (EscreveHi),
    .EscreveLo (EscreveLo),
    .Ocupado   (Ocupado),
    .Pronto    (Pronto),
    .DivPorZero(DivPorZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MIPS semantics with plain 64-bit arithmetic; division by zero keeps HI/LO.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi_o, input logic [31:0] lo_o,
                                output logic [31:0] hi_n, output logic [31:0] lo_n, output logic dz);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = op[0] ? {32'b0, a} : {{32{a[31]}}, a};
    sb = op[0] ? {32'b0, b} : {{32{b[31]}}, b};
    dz = 1'b0;
    hi_n = hi_o;
    lo_n = lo_o;
    if (!op[1]) begin
      p = sa * sb;
      hi_n = p[63:32];
      lo_n = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      hi_n = r[31:0];
      lo_n = q[31:0];
    end
  endfunction

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj_k, input logic inj_wr, input logic start_wr);
    logic [31:0] ehi, elo, rhi, rlo;
    logic        edz, rdz, hold_ok;
    int          ocup, pr_at, pr_cnt;
    model(op, a, b, hi_m, lo_m, ehi, elo, edz);
    @(negedge Clock);
    Inicio = 1'b1; Operacao = op; OperandoA = a; OperandoB = b;
    EscreveHi = start_wr; EscreveLo = start_wr;
    ocup = 0; pr_at = 0; pr_cnt = 0; hold_ok = 1'b1;
    rhi = 'x; rlo = 'x; rdz = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clock);
      if (Ocupado) begin
        ocup++;
        if (Hi !== hi_m || Lo !== lo_m) hold_ok = 1'b0;
      end
      if (Pronto) begin
        pr_cnt++;
        if (pr_at == 0) begin
          pr_at = k; rhi = Hi; rlo = Lo; rdz = DivPorZero;
        end
      end
      Inicio = 1'b0; EscreveHi = 1'b0; EscreveLo = 1'b0;
      OperandoA = $urandom; OperandoB = $urandom; Operacao = 2'($urandom_range(0, 3));
      if (k == inj_k) begin
        Inicio = 1'b1; EscreveLo = inj_wr;
      end
    end
    chk({tag, " pronto_cycle"}, pr_at, 34);
    chk({tag, " pronto_count"}, pr_cnt, 1);
    chk({tag, " ocupado_cycles"}, ocup, 33);
    chk({tag, " hilo_hold"}, {31'b0, hold_ok}, 1);
    chk({tag, " hi"}, rhi, ehi);
    chk({tag, " lo"}, rlo, elo);
    chk({tag, " divporzero"}, {31'b0, rdz}, {31'b0, edz});
    chk({tag, " hi_after"}, Hi, ehi);
    chk({tag, " lo_after"}, Lo, elo);
    hi_m = ehi;
    lo_m = elo;
  endtask

  task automatic mt_write(input logic wh, input logic wl, input logic [31:0] a);
    @(negedge Clock);
    EscreveHi = wh; EscreveLo = wl; OperandoA = a;
    @(negedge Clock);
    EscreveHi = 1'b0; EscreveLo = 1'b0; OperandoA = $urandom;
    if (wh) hi_m = a;
    if (wl) lo_m = a;
    chk("mt hi", Hi, hi_m);
    chk("mt lo", Lo, lo_m);
  endtask

  initial begin
    int pr_seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    Reset = 1'b1; Inicio = 1'b0; Operacao = 2'b00; OperandoA = '0; OperandoB = '0;
    EscreveHi = 1'b0; EscreveLo = 1'b0;
    hi_m = '0; lo_m = '0;
    @(negedge Clock);
    @(negedge Clock);
    chk("reset hi", Hi, 0);
    chk("reset lo", Lo, 0);
    chk("reset ocupado", {31'b0, Ocupado}, 0);
    chk("reset pronto", {31'b0, Pronto}, 0);
    chk("reset divporzero", {31'b0, DivPorZero}, 0);
    Reset = 1'b0;

    do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    chk("multu_max hi_const", Hi, 32'hFFFF_FFFE);
    chk("multu_max lo_const", Lo, 32'h0000_0001);
    do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, 1'b0);
    chk("mult_neg lo_const", Lo, 32'hFFFF_FFEB);
    do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 1'b0);
    chk("div_neg lo_const", Lo, 32'hFFFF_FFFD);
    chk("div_neg hi_const", Hi, 32'hFFFF_FFFF);
    do_op("divu_small", 2'b11, 32'd7, 32'd2, 0, 1'b0, 1'b0);
    chk("divu_small lo_const", Lo, 32'd3);
    chk("divu_small hi_const", Hi, 32'd1);

    mt_write(1'b1, 1'b1, 32'h5A5A_0F0F);
    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    do_op("divu_zero", 2'b11, 32'd5, 32'd0, 0, 1'b0, 1'b0);
    chk("divu_zero hi_const", Hi, 32'h11);
    chk("divu_zero lo_const", Lo, 32'h22);

    do_op("multu_inj", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b1, 1'b0);
    mt_write(1'b1, 1'b0, 32'hCAFE_BABE);
    chk("mthi cafebabe", Hi, 32'hCAFE_BABE);

    do_op("start_with_write", 2'b00, 32'h8000_0001, 32'hFFFF_0003, 0, 1'b0, 1'b1);
    do_op("inicio_in_fim", 2'b10, 32'd1000, 32'hFFFF_FFF3, 34, 1'b0, 1'b0);
    do_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
    chk("div_overflow lo_const", Lo, 32'h8000_0000);
    chk("div_overflow hi_const", Hi, 32'h0000_0000);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
      do_op("random", rop, ra, rb, 0, 1'b0, 1'b0);
    end

    @(negedge Clock);
    Inicio = 1'b1; Operacao = 2'b10; OperandoA = 32'd12345; OperandoB = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      Inicio = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clock);
    chk("midreset ocupado", {31'b0, Ocupado}, 0);
    chk("midreset pronto", {31'b0, Pronto}, 0);
    chk("midreset hi", Hi, 0);
    chk("midreset lo", Lo, 0);
    Reset = 1'b0;
    pr_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (Pronto) pr_seen++;
    end
    chk("midreset no_pronto", pr_seen, 0);
    chk("midreset hi_after", Hi, 0);
    chk("midreset lo_after", Lo, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
